// File: rtl/pattern_pkg.sv
// Shared types and constants for the test-pattern stream generator.
package pattern_pkg;

    localparam int unsigned RGB_W  = 24;
    localparam int unsigned WORD_W = 32;

    typedef logic [RGB_W-1:0]  rgb24_t;
    typedef logic [WORD_W-1:0] word32_t;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [1:0] MODE_CIRCLE = 2'd0;
    localparam logic [1:0] MODE_BARS   = 2'd1;
    localparam logic [1:0] MODE_CHECK  = 2'd2;
    localparam logic [1:0] MODE_SOLID  = 2'd3;

    // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
    localparam rgb24_t [7:0] BAR_ROM = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

endpackage

// File: rtl/rgb24_packer.sv
// Packs four 24-bit pixels into three 32-bit stream words behind a registered output.
module rgb24_packer
    import pattern_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [23:0] pix_data,
    input  logic        pix_sof,
    input  logic        pix_eol,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        m_tuser
);

    logic [1:0] phase_q, phase_d;
    rgb24_t     part_q, part_d;
    logic       sof_q, sof_d;
    word32_t    tdata_q, tdata_d;
    logic       tvalid_q, tvalid_d;
    logic       tlast_q, tlast_d;
    logic       tuser_q, tuser_d;
    logic       out_free;
    logic       take;

    // Phase 0 only fills the partial register, so it never needs the output slot.
    assign out_free  = !tvalid_q || m_tready;
    assign pix_ready = (phase_q == 2'd0) || out_free;
    assign take      = pix_valid && pix_ready;

    // Next-state for phase, partial word and output register.
    always_comb begin
        phase_d  = phase_q;
        part_d   = part_q;
        sof_d    = sof_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        if (tvalid_q && m_tready) begin
            tvalid_d = 1'b0;
        end
        if (take) begin
            phase_d = phase_q + 2'd1;
            case (phase_q)
                2'd0: begin
                    part_d = pix_data;
                    sof_d  = pix_sof;
                end
                2'd1: begin
                    tdata_d  = {pix_data[7:0], part_q};
                    part_d   = {8'h00, pix_data[23:8]};
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    tuser_d  = sof_q;
                end
                2'd2: begin
                    tdata_d  = {pix_data[15:0], part_q[15:0]};
                    part_d   = {16'h0000, pix_data[23:16]};
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    tuser_d  = 1'b0;
                end
                default: begin
                    tdata_d  = {pix_data, part_q[7:0]};
                    tvalid_d = 1'b1;
                    tlast_d  = pix_eol;
                    tuser_d  = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            phase_q  <= 2'd0;
            part_q   <= '0;
            sof_q    <= 1'b0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            part_q   <= part_d;
            sof_q    <= sof_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
        end
    end

    assign m_tdata  = tdata_q;
    assign m_tvalid = tvalid_q;
    assign m_tlast  = tlast_q;
    assign m_tuser  = tuser_q;

endmodule

// File: rtl/pattern_stream_gen.sv
// Frame-based RGB test-pattern source driving a packed 32-bit AXI4-Stream.
module pattern_stream_gen
    import pattern_pkg::*;
#(
    parameter int unsigned X_SIZE     = 640,
    parameter int unsigned Y_SIZE     = 480,
    parameter int unsigned XW         = $clog2(X_SIZE),
    parameter int unsigned YW         = $clog2(Y_SIZE),
    parameter int unsigned CHECK_LOG2 = 5
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic [23:0]   solid_rgb,
    input  logic [XW-1:0] cx,
    input  logic [YW-1:0] cy,
    input  logic [XW-1:0] radius,
    input  logic [XW-1:0] thickness,
    output logic [31:0]   out_stream_tdata,
    output logic [3:0]    out_stream_tkeep,
    output logic          out_stream_tlast,
    output logic          out_stream_tvalid,
    input  logic          out_stream_tready,
    output logic          out_stream_tuser,
    output logic [15:0]   frame_count,
    output logic          busy
);

    localparam int unsigned DW = 2 * XW + 2;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          gen_done_q, gen_done_d;
    logic [YW-1:0] line_q, line_d;
    logic [15:0]   fcnt_q, fcnt_d;
    logic [1:0]    mode_q, mode_d;
    rgb24_t        solid_q, solid_d;
    logic [XW-1:0] cx_q, cx_d, rad_q, rad_d, thk_q, thk_d;
    logic [YW-1:0] cy_q, cy_d;

    logic          pix_valid, pix_ready, pix_take, pix_sof, pix_eol;
    rgb24_t        pix_rgb;
    logic          acc, frame_end;

    logic signed [DW-1:0] dx, dy, d2;
    logic [DW-1:0]        r_out2, r_in2;
    logic [XW-1:0]        r_in;
    logic [XW+2:0]        x8;
    logic [2:0]           bar_idx;

    // Generation pauses once the whole frame is in the packer until its last word drains.
    assign pix_valid = (state_q == StRun) && !gen_done_q;
    assign pix_take  = pix_valid && pix_ready;
    assign pix_sof   = (x_q == '0) && (y_q == '0);
    assign pix_eol   = (x_q == XW'(X_SIZE - 1));
    assign acc       = out_stream_tvalid && out_stream_tready;
    assign frame_end = acc && out_stream_tlast && (line_q == YW'(Y_SIZE - 1));

    // Pattern function of the current pixel coordinate and the shadowed controls.
    always_comb begin
        dx      = $signed(DW'(x_q)) - $signed(DW'(cx_q));
        dy      = $signed(DW'(y_q)) - $signed(DW'(cy_q));
        d2      = dx * dx + dy * dy;
        r_in    = rad_q - thk_q;
        r_out2  = DW'(rad_q) * DW'(rad_q);
        r_in2   = DW'(r_in) * DW'(r_in);
        x8      = {x_q, 3'b000};
        bar_idx = 3'(32'(x8) / X_SIZE);
        pix_rgb = solid_q;
        case (mode_q)
            MODE_CIRCLE: pix_rgb = (($unsigned(d2) >= r_in2) && ($unsigned(d2) <= r_out2))
                                   ? 24'h000000 : 24'hFFFFFF;
            MODE_BARS:   pix_rgb = BAR_ROM[bar_idx];
            MODE_CHECK:  pix_rgb = (x_q[CHECK_LOG2] ^ y_q[CHECK_LOG2]) ? 24'hFFFFFF : 24'h000000;
            default:     pix_rgb = solid_q;
        endcase
    end

    // FSM, pixel counter, output line tracking and shadow-register capture.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        gen_done_d = gen_done_q;
        line_d     = line_q;
        fcnt_d     = fcnt_q;
        mode_d     = mode_q;
        solid_d    = solid_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        rad_d      = rad_q;
        thk_d      = thk_q;

        if (pix_take) begin
            if (pix_eol) begin
                x_d = '0;
                if (y_q == YW'(Y_SIZE - 1)) begin
                    y_d        = '0;
                    gen_done_d = 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        if (acc && out_stream_tlast) begin
            line_d = (line_q == YW'(Y_SIZE - 1)) ? '0 : line_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StRun;
                    mode_d  = mode;
                    solid_d = solid_rgb;
                    cx_d    = cx;
                    cy_d    = cy;
                    rad_d   = radius;
                    thk_d   = thickness;
                end
            end
            default: begin
                if (frame_end) begin
                    fcnt_d     = fcnt_q + 16'd1;
                    gen_done_d = 1'b0;
                    if (enable) begin
                        mode_d  = mode;
                        solid_d = solid_rgb;
                        cx_d    = cx;
                        cy_d    = cy;
                        rad_d   = radius;
                        thk_d   = thickness;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            gen_done_q <= 1'b0;
            line_q     <= '0;
            fcnt_q     <= '0;
            mode_q     <= '0;
            solid_q    <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            rad_q      <= '0;
            thk_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            gen_done_q <= gen_done_d;
            line_q     <= line_d;
            fcnt_q     <= fcnt_d;
            mode_q     <= mode_d;
            solid_q    <= solid_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            rad_q      <= rad_d;
            thk_q      <= thk_d;
        end
    end

    rgb24_packer u_packer (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_rgb),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol),
        .m_tdata   (out_stream_tdata),
        .m_tvalid  (out_stream_tvalid),
        .m_tready  (out_stream_tready),
        .m_tlast   (out_stream_tlast),
        .m_tuser   (out_stream_tuser)
    );

    assign out_stream_tkeep = 4'hF;
    assign frame_count      = fcnt_q;
    assign busy             = (state_q == StRun);

endmodule
